// File: rtl/ex_alu_core.sv
// Execute-stage ALU: scalar RV32 integer ops, branch/jump resolution and an
// optional 4x4 signed int8 vector-matrix unit (MATRIX_MUL_EN); one-cycle latency.
module ex_alu_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [2:0]   alu_op,
  input  logic [2:0]   func3,
  input  logic         func7,
  input  logic [31:0]  op_A,
  input  logic [31:0]  op_B,
  input  logic [127:0] M,
  output logic         out_valid,
  output logic [31:0]  alu_o,
  output logic         br_mark,
  output logic [127:0] mat_o
);

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_BRANCH = 3'b001,
    OP_RTYPE  = 3'b010,
    OP_ITYPE  = 3'b011,
    OP_JUMP   = 3'b100,
    OP_MATRIX = 3'b101
  } alu_op_e;

  typedef enum logic [3:0] {
    CTRL_ADD  = 4'd0,
    CTRL_SUB  = 4'd1,
    CTRL_SLL  = 4'd2,
    CTRL_SLT  = 4'd3,
    CTRL_SLTU = 4'd4,
    CTRL_XOR  = 4'd5,
    CTRL_SRL  = 4'd6,
    CTRL_SRA  = 4'd7,
    CTRL_OR   = 4'd8,
    CTRL_AND  = 4'd9
  } alu_ctrl_e;

  alu_ctrl_e   alu_ctrl;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;
  logic        eq;
  logic        lt_s;
  logic        lt_u;
  logic [31:0] alu_res;
  logic [31:0] alu_nxt;
  logic        br_nxt;

  // Control decode; I-type ignores func7 for func3 000 because that bit is immediate data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    alu_ctrl = CTRL_ADD;
    case (alu_op)
      OP_BRANCH: alu_ctrl = CTRL_SUB;
      OP_RTYPE, OP_ITYPE: begin
        case (func3)
          3'b000:  alu_ctrl = (func7 && alu_op == OP_RTYPE) ? CTRL_SUB : CTRL_ADD;
          3'b001:  alu_ctrl = CTRL_SLL;
          3'b010:  alu_ctrl = CTRL_SLT;
          3'b011:  alu_ctrl = CTRL_SLTU;
          3'b100:  alu_ctrl = CTRL_XOR;
          3'b101:  alu_ctrl = func7 ? CTRL_SRA : CTRL_SRL;
          3'b110:  alu_ctrl = CTRL_OR;
          default: alu_ctrl = CTRL_AND;
        endcase
      end
      default: alu_ctrl = CTRL_ADD;
    endcase
  end

  assign sum   = op_A + op_B;
  assign diff  = op_A - op_B;
  assign shamt = op_B[4:0];
  assign eq    = (op_A == op_B);
  assign lt_s  = ($signed(op_A) < $signed(op_B));
  assign lt_u  = (op_A < op_B);

  always_comb begin
    alu_res = sum;
    case (alu_ctrl)
      CTRL_ADD:  alu_res = sum;
      CTRL_SUB:  alu_res = diff;
      CTRL_SLL:  alu_res = op_A << shamt;
      CTRL_SLT:  alu_res = {31'd0, lt_s};
      CTRL_SLTU: alu_res = {31'd0, lt_u};
      CTRL_XOR:  alu_res = op_A ^ op_B;
      CTRL_SRL:  alu_res = op_A >> shamt;
      CTRL_SRA:  alu_res = $unsigned($signed(op_A) >>> shamt);
      CTRL_OR:   alu_res = op_A | op_B;
      CTRL_AND:  alu_res = op_A & op_B;
      default:   alu_res = sum;
    endcase
  end

  always_comb begin
    br_nxt = 1'b0;
    if (alu_op == OP_BRANCH) begin
      case (func3)
        3'b000:  br_nxt = eq;
        3'b001:  br_nxt = !eq;
        3'b100:  br_nxt = lt_s;
        3'b101:  br_nxt = !lt_s;
        3'b110:  br_nxt = lt_u;
        3'b111:  br_nxt = !lt_u;
        default: br_nxt = 1'b0;
      endcase
    end else if (alu_op == OP_JUMP) begin
      br_nxt = 1'b1;
    end
  end

`ifdef MATRIX_MUL_EN
  logic [127:0] mat_nxt;

  // One output lane: dot product of the a-vector with column j of M, sign-extended.
  function automatic logic [31:0] mac_lane(input logic [31:0] a, input logic [127:0] m,
                                           input int j);
    logic [31:0]        acc;
    logic signed [7:0]  ea;
    logic signed [7:0]  eb;
    logic signed [15:0] p;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      ea  = a[8*i +: 8];
      eb  = m[32*i + 8*j +: 8];
      p   = 16'(ea) * 16'(eb);
      acc = acc + {{16{p[15]}}, p};
    end
    return acc;
  endfunction

  always_comb begin
    mat_nxt = '0;
    if (alu_op == OP_MATRIX && func3[2:1] == 2'b00) begin
      for (int j = 0; j < 4; j++) begin
        mat_nxt[32*j +: 32] = mac_lane(op_A, M, j) + (func3[0] ? op_B : 32'd0);
      end
    end
  end

  assign alu_nxt = (alu_op == OP_MATRIX) ? mat_nxt[31:0] : alu_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_o <= '0;
    end else if (in_valid) begin
      mat_o <= mat_nxt;
    end
  end
`else
  // Without the matrix unit, class 101 simply falls through to ADD and M is ignored.
  logic unused_m;
  assign unused_m = ^M;
  assign alu_nxt  = alu_res;
  assign mat_o    = '0;
`endif

  // Results hold across idle cycles; only out_valid tracks in_valid every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_o     <= '0;
      br_mark   <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      out_valid <= in_valid;
      if (in_valid) begin
        alu_o   <= alu_nxt;
        br_mark <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_core.sv
// Directed self-checking bench for ex_alu_core; matrix expectations follow
// whether MATRIX_MUL_EN is defined for the build.
module tb_ex_alu_core;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [2:0]   alu_op;
  logic [2:0]   func3;
  logic         func7;
  logic [31:0]  op_A;
  logic [31:0]  op_B;
  logic [127:0] M;
  logic         out_valid;
  logic [31:0]  alu_o;
  logic         br_mark;
  logic [127:0] mat_o;

  int check_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu;
    logic        br;
  } vec_t;

  ex_alu_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .func3     (func3),
    .func7     (func7),
    .op_A      (op_A),
    .op_B      (op_B),
    .M         (M),
    .out_valid (out_valid),
    .alu_o     (alu_o),
    .br_mark   (br_mark),
    .mat_o     (mat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one valid transaction and step to just after the capturing edge.
  task automatic apply(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    func3    = f3;
    func7    = f7;
    op_A     = a;
    op_B     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    check_cnt++;
    if (alu_o !== 32'd0) $display("FAIL reset_alu: got %h expected 00000000", alu_o);
    else pass_cnt++;
    check_cnt++;
    if (br_mark !== 1'b0) $display("FAIL reset_br: got %b expected 0", br_mark);
    else pass_cnt++;
    check_cnt++;
    if (mat_o !== 128'd0) $display("FAIL reset_mat: got %h expected 0", mat_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu();
    vec_t v[12];
    v = '{
      '{3'b010, 3'b000, 1'b1, 32'd5,          32'd7,          32'hFFFFFFFE, 1'b0},
      '{3'b010, 3'b000, 1'b0, 32'hFFFFFFFF,   32'd1,          32'h00000000, 1'b0},
      '{3'b010, 3'b001, 1'b0, 32'd1,          32'h21,         32'h00000002, 1'b0},
      '{3'b010, 3'b010, 1'b0, 32'hFFFFFFFF,   32'd1,          32'h00000001, 1'b0},
      '{3'b010, 3'b011, 1'b0, 32'hFFFFFFFF,   32'd1,          32'h00000000, 1'b0},
      '{3'b010, 3'b100, 1'b0, 32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0, 1'b0},
      '{3'b010, 3'b101, 1'b0, 32'h80000000,   32'd4,          32'h08000000, 1'b0},
      '{3'b010, 3'b101, 1'b1, 32'h80000000,   32'd4,          32'hF8000000, 1'b0},
      '{3'b010, 3'b110, 1'b0, 32'h000000F0,   32'h0000000F,   32'h000000FF, 1'b0},
      '{3'b010, 3'b111, 1'b0, 32'h000000F0,   32'h0000003C,   32'h00000030, 1'b0},
      '{3'b011, 3'b000, 1'b1, 32'd5,          32'd7,          32'h0000000C, 1'b0},
      '{3'b011, 3'b101, 1'b1, 32'h80000000,   32'h24,         32'hF8000000, 1'b0}
    };
    for (int i = 0; i < 12; i++) begin
      apply(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b);
      check_cnt++;
      if (out_valid !== 1'b1) $display("FAIL alu_valid[%0d]: got %b expected 1", i, out_valid);
      else pass_cnt++;
      check_cnt++;
      if (alu_o !== v[i].alu) $display("FAIL alu_res[%0d]: got %h expected %h", i, alu_o, v[i].alu);
      else pass_cnt++;
      check_cnt++;
      if (br_mark !== v[i].br) $display("FAIL alu_br[%0d]: got %b expected %b", i, br_mark, v[i].br);
      else pass_cnt++;
    end
  endtask

  task automatic test_branch_jump();
    vec_t v[10];
    v = '{
      '{3'b001, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b1},
      '{3'b001, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 1'b0},
      '{3'b001, 3'b000, 1'b0, 32'd3,        32'd3,        32'h00000000, 1'b1},
      '{3'b001, 3'b001, 1'b0, 32'd3,        32'd3,        32'h00000000, 1'b0},
      '{3'b001, 3'b101, 1'b0, 32'd1,        32'hFFFFFFFF, 32'h00000002, 1'b1},
      '{3'b001, 3'b111, 1'b0, 32'd1,        32'hFFFFFFFF, 32'h00000002, 1'b0},
      '{3'b001, 3'b010, 1'b0, 32'd3,        32'd3,        32'h00000000, 1'b0},
      '{3'b100, 3'b000, 1'b0, 32'h00001000, 32'd4,        32'h00001004, 1'b1},
      '{3'b000, 3'b111, 1'b1, 32'h00000010, 32'h20,       32'h00000030, 1'b0},
      '{3'b110, 3'b001, 1'b0, 32'd1,        32'd2,        32'h00000003, 1'b0}
    };
    for (int i = 0; i < 10; i++) begin
      apply(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b);
      check_cnt++;
      if (br_mark !== v[i].br) $display("FAIL br_mark[%0d]: got %b expected %b", i, br_mark, v[i].br);
      else pass_cnt++;
      check_cnt++;
      if (alu_o !== v[i].alu) $display("FAIL br_alu[%0d]: got %h expected %h", i, alu_o, v[i].alu);
      else pass_cnt++;
      check_cnt++;
      if (mat_o !== 128'd0) $display("FAIL br_mat[%0d]: got %h expected 0", i, mat_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_matrix();
    logic [127:0] exp_mat0;
    logic [127:0] exp_mat1;
    logic [127:0] exp_mat2;
    logic [31:0]  exp_alu0;
    logic [31:0]  exp_alu1;
    logic [31:0]  exp_alu2;
    M = {32'h00000000, 32'h02020202, 32'h01010101, 32'h04030201};
`ifdef MATRIX_MUL_EN
    // a = {1, 2, -1, 1}: lane j = M[0][j] + 2*1 - 1*2 + 0 = j+1
    exp_mat0 = {32'd4, 32'd3, 32'd2, 32'd1};
    exp_mat1 = {32'd14, 32'd13, 32'd12, 32'd11};
    exp_mat2 = 128'd0;
    exp_alu0 = 32'd1;
    exp_alu1 = 32'd11;
    exp_alu2 = 32'd0;
`else
    exp_mat0 = 128'd0;
    exp_mat1 = 128'd0;
    exp_mat2 = 128'd0;
    exp_alu0 = 32'h01FF020B;
    exp_alu1 = 32'h01FF020B;
    exp_alu2 = 32'h01FF020B;
`endif
    apply(3'b101, 3'b000, 1'b0, 32'h01FF0201, 32'd10);
    check_cnt++;
    if (mat_o !== exp_mat0) $display("FAIL mat_plain: got %h expected %h", mat_o, exp_mat0);
    else pass_cnt++;
    check_cnt++;
    if (alu_o !== exp_alu0) $display("FAIL mat_plain_alu: got %h expected %h", alu_o, exp_alu0);
    else pass_cnt++;
    apply(3'b101, 3'b001, 1'b0, 32'h01FF0201, 32'd10);
    check_cnt++;
    if (mat_o !== exp_mat1) $display("FAIL mat_bias: got %h expected %h", mat_o, exp_mat1);
    else pass_cnt++;
    check_cnt++;
    if (alu_o !== exp_alu1) $display("FAIL mat_bias_alu: got %h expected %h", alu_o, exp_alu1);
    else pass_cnt++;
    check_cnt++;
    if (br_mark !== 1'b0) $display("FAIL mat_br: got %b expected 0", br_mark);
    else pass_cnt++;
    apply(3'b101, 3'b010, 1'b0, 32'h01FF0201, 32'd10);
    check_cnt++;
    if (mat_o !== exp_mat2) $display("FAIL mat_resv: got %h expected %h", mat_o, exp_mat2);
    else pass_cnt++;
    check_cnt++;
    if (alu_o !== exp_alu2) $display("FAIL mat_resv_alu: got %h expected %h", alu_o, exp_alu2);
    else pass_cnt++;
`ifdef MATRIX_MUL_EN
    // all elements -1 against all 127: every lane = -508
    M = {4{32'h7F7F7F7F}};
    apply(3'b101, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd0);
    check_cnt++;
    if (mat_o !== {4{32'hFFFFFE04}}) $display("FAIL mat_neg: got %h expected %h", mat_o, {4{32'hFFFFFE04}});
    else pass_cnt++;
`endif
    M = '0;
  endtask

  task automatic test_hold();
    apply(3'b100, 3'b000, 1'b0, 32'h00000200, 32'd8);
    in_valid = 1'b0;
    op_A     = 32'hDEADBEEF;
    alu_op   = 3'b010;
    @(posedge clk);
    #1;
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL hold_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    check_cnt++;
    if (alu_o !== 32'h00000208) $display("FAIL hold_alu: got %h expected 00000208", alu_o);
    else pass_cnt++;
    check_cnt++;
    if (br_mark !== 1'b1) $display("FAIL hold_br: got %b expected 1", br_mark);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    apply(3'b010, 3'b000, 1'b0, 32'd100, 32'd1);
    check_cnt++;
    if (out_valid !== 1'b1 || alu_o !== 32'd101) $display("FAIL b2b_0: got %b/%h expected 1/00000065", out_valid, alu_o);
    else pass_cnt++;
    apply(3'b010, 3'b000, 1'b1, 32'd100, 32'd1);
    check_cnt++;
    if (out_valid !== 1'b1 || alu_o !== 32'd99) $display("FAIL b2b_1: got %b/%h expected 1/00000063", out_valid, alu_o);
    else pass_cnt++;
    apply(3'b010, 3'b001, 1'b0, 32'd100, 32'd2);
    check_cnt++;
    if (out_valid !== 1'b1 || alu_o !== 32'd400) $display("FAIL b2b_2: got %b/%h expected 1/00000190", out_valid, alu_o);
    else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply(3'b100, 3'b000, 1'b0, 32'h00000100, 32'd4);
    check_cnt++;
    if (out_valid !== 1'b1 || br_mark !== 1'b1 || alu_o !== 32'h104)
      $display("FAIL rstmid_pre: got %b/%b/%h expected 1/1/00000104", out_valid, br_mark, alu_o);
    else pass_cnt++;
    // next R-type ADD is in flight when reset hits
    in_valid = 1'b1;
    alu_op   = 3'b010;
    func3    = 3'b000;
    func7    = 1'b0;
    op_A     = 32'd2;
    op_B     = 32'd3;
    #3;
    rst = 1'b1;
    #1;
    check_cnt++;
    if (out_valid !== 1'b0 || alu_o !== 32'd0 || br_mark !== 1'b0 || mat_o !== 128'd0)
      $display("FAIL rstmid_async: got %b/%h/%b expected 0/00000000/0", out_valid, alu_o, br_mark);
    else pass_cnt++;
    @(posedge clk);
    #1;
    check_cnt++;
    if (out_valid !== 1'b0 || alu_o !== 32'd0) $display("FAIL rstmid_edge: got %b/%h expected 0/00000000", out_valid, alu_o);
    else pass_cnt++;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_cnt++;
    if (out_valid !== 1'b0 || alu_o !== 32'd0) $display("FAIL rstmid_idle: got %b/%h expected 0/00000000", out_valid, alu_o);
    else pass_cnt++;
    apply(3'b010, 3'b000, 1'b0, 32'd2, 32'd3);
    check_cnt++;
    if (out_valid !== 1'b1 || alu_o !== 32'd5) $display("FAIL rstmid_resume: got %b/%h expected 1/00000005", out_valid, alu_o);
    else pass_cnt++;
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    alu_op   = 3'b000;
    func3    = 3'b000;
    func7    = 1'b0;
    op_A     = '0;
    op_B     = '0;
    M        = '0;
    test_reset();
    test_alu();
    test_branch_jump();
    test_matrix();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
